// File: rtl/prng.sv
// prng -- free-running 32-bit PCG32 (XSH-RR) pseudo-random word generator.
//
// A 64-bit LCG state advances once per enabled clock. Each new output word is
// the xorshift-high / random-rotate permutation of the state *before* that
// advance, so dout after edge k is P(state before edge k).
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-high reset: state <= SEED, dout <= 0
//   en          advance enable (defaults high so a bare instance free-runs)
//   seed_valid  load 'seed' into the state this cycle; dout holds; beats en
//   seed        new 64-bit state value
//   dout        registered 32-bit random word
module prng #(
   parameter logic [63:0] SEED = 64'h0000_0000_0000_0000,
   parameter logic [63:0] MULT = 64'h5851_F42D_4C95_7F2D,
   parameter logic [63:0] INC  = 64'h1405_7B7E_F767_814F
) (
   input  logic        clk,
   input  logic        rst        = 1'b0,
   input  logic        en         = 1'b1,
   input  logic        seed_valid = 1'b0,
   input  logic [63:0] seed       = 64'd0,
   output logic [31:0] dout
);

   // Declaration initialisers give a deterministic start when rst is never used.
   logic [63:0] state = SEED;
   logic [31:0] dout_q = 32'd0;

   // ------------------------------------------------------------------
   // Output permutation on the current state
   // ------------------------------------------------------------------
   logic [31:0] xsh;
   logic [4:0]  rot_r;
   logic [4:0]  rot_l;
   logic [31:0] perm;

   always_comb begin
      xsh   = 32'(((state >> 18) ^ state) >> 27);
      rot_r = state[63:59];
      // (32 - r) & 31 == two's-complement negate in 5 bits; r=0 gives a shift of 0
      rot_l = 5'd0 - rot_r;
      perm  = (xsh >> rot_r) | (xsh << rot_l);
   end

   // ------------------------------------------------------------------
   // LCG step, mod 2^64. Only the low 64 product bits matter, so the
   // hi*hi partial product drops out and the cross terms only need
   // their low 32 bits.
   // ------------------------------------------------------------------
   logic [31:0] s_lo, s_hi, m_lo, m_hi;
   logic [63:0] p_ll;
   logic [31:0] p_cross;
   logic [63:0] state_next;

   always_comb begin
      s_lo       = state[31:0];
      s_hi       = state[63:32];
      m_lo       = MULT[31:0];
      m_hi       = MULT[63:32];
      p_ll       = 64'(s_lo) * 64'(m_lo);
      p_cross    = (s_lo * m_hi) + (s_hi * m_lo);
      state_next = p_ll + {p_cross, 32'd0} + INC;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= SEED;
         dout_q <= 32'd0;
      end else if (seed_valid) begin
         state  <= seed;
      end else if (en) begin
         state  <= state_next;
         dout_q <= perm;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_prng.sv
module tb_prng;

   localparam logic [63:0] MULT = 64'h5851_F42D_4C95_7F2D;
   localparam logic [63:0] INC  = 64'h1405_7B7E_F767_814F;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        seed_valid;
   logic [63:0] seed;
   logic [31:0] dout;

   int n_cmp = 0;
   int n_bad = 0;

   prng dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .seed_valid (seed_valid),
      .seed       (seed),
      .dout       (dout)
   );

   always #5 clk = ~clk;

   // Reference PCG32 (XSH-RR), written the way the C reference does it.
   function automatic logic [31:0] pcg_out(input logic [63:0] old);
      logic [31:0] xs;
      int unsigned rot;
      xs  = 32'(((old >> 18) ^ old) >> 27);
      rot = int'(old >> 59);
      return (xs >> rot) | (xs << ((32 - rot) % 32));
   endfunction

   function automatic logic [63:0] pcg_step(input logic [63:0] old);
      return old * MULT + INC;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        sv;
      logic [63:0] sd;
      logic        e;
      logic [31:0] exp_dout;
      logic [63:0] exp_state;
   } vec_t;

   vec_t vecs[9];
   logic [63:0] mstate;
   logic [31:0] mdout;

   initial begin
      // sv, seed, en, dout after edge, state after edge
      vecs[0] = '{1'b0, 64'd0,                  1'b1, 32'h0000_0000, 64'h1405_7B7E_F767_814F};
      vecs[1] = '{1'b1, 64'd1,                  1'b1, 32'h0000_0000, 64'h0000_0000_0000_0001};
      vecs[2] = '{1'b0, 64'd0,                  1'b1, 32'h0000_0000, 64'h6C57_6FAC_43FD_007C};
      vecs[3] = '{1'b1, 64'h0800_0000_0000_0000, 1'b1, 32'h0000_0000, 64'h0800_0000_0000_0000};
      vecs[4] = '{1'b0, 64'd0,                  1'b1, 32'h0000_2000, 64'h7C05_7B7E_F767_814F};
      vecs[5] = '{1'b1, 64'hF800_0000_0000_0000, 1'b0, 32'h0000_2000, 64'hF800_0000_0000_0000};
      vecs[6] = '{1'b0, 64'd0,                  1'b1, 32'h000F_8000, 64'hAC05_7B7E_F767_814F};
      vecs[7] = '{1'b0, 64'd0,                  1'b0, 32'h000F_8000, 64'hAC05_7B7E_F767_814F};
      vecs[8] = '{1'b1, 64'd1,                  1'b0, 32'h000F_8000, 64'h0000_0000_0000_0001};

      rst = 1'b1; en = 1'b1; seed_valid = 1'b0; seed = 64'd0;
      #12;
      check("reset_dout",  64'(dout), 64'd0);
      check("reset_state", dut.state, 64'd0);
      tick;
      check("reset_hold_dout", 64'(dout), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // directed vectors
      for (int i = 0; i < 9; i++) begin
         seed_valid = vecs[i].sv;
         seed       = vecs[i].sd;
         en         = vecs[i].e;
         tick;
         check($sformatf("vec%0d_dout", i),  64'(dout), 64'(vecs[i].exp_dout));
         check($sformatf("vec%0d_state", i), dut.state, vecs[i].exp_state);
      end
      seed_valid = 1'b0;

      // stream from state 1, freeze 10 cycles, resume with no skipped value
      mstate = 64'd1;
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         mdout  = pcg_out(mstate);
         mstate = pcg_step(mstate);
         check($sformatf("pre_freeze%0d", i), 64'(dout), 64'(mdout));
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick;
         check($sformatf("freeze_dout%0d", i),  64'(dout), 64'(mdout));
         check($sformatf("freeze_state%0d", i), dut.state, mstate);
      end
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         mdout  = pcg_out(mstate);
         mstate = pcg_step(mstate);
         check($sformatf("resume%0d", i), 64'(dout), 64'(mdout));
      end

      // asynchronous reset pulse between edges
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_dout",  64'(dout), 64'd0);
      check("async_rst_state", dut.state, 64'd0);
      tick;
      check("async_rst_held_state", dut.state, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // restart from SEED: first word P(0)=0, then follow the reference model
      mstate = 64'd0;
      for (int i = 0; i < 2000; i++) begin
         tick;
         mdout  = pcg_out(mstate);
         mstate = pcg_step(mstate);
         if (i == 0) check("restart_edge1", 64'(dout), 64'd0);
         else if (i == 1) check("restart_edge1_state", 64'(pcg_step(64'd0)), 64'h1405_7B7E_F767_814F);
         check($sformatf("run%0d", i), 64'(dout), 64'(mdout));
      end
      check("run_final_state", dut.state, mstate);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
